// File: rtl/busdebugger_command_rx.sv
// busdebugger_command_rx
//   Serial receive path of the bus debugger: UART receiver (8N1, or 8E1 when
//   BUSDEBUGGER_CMD_RX_PARITY_EN is defined) feeding an ASCII command decoder.
//   Commands (case-insensitive): D dump start, R record start, T record
//   trigger, A<BITWIDTH/4 hex digits> load trigger address. CR/LF/space ignored.
// Ports
//   serial_clock        sole clock
//   reset               async active-low reset
//   clocks_per_bit      cycles per bit (N >= 4), held stable while busy
//   rx_pin              UART line, idles high
//   dump_start          1-cycle pulse on D
//   record_start        1-cycle pulse on R
//   record_trigger      1-cycle pulse on T
//   trigger_addr        last fully received A argument
//   trigger_addr_valid  1-cycle pulse when trigger_addr updates
//   cmd_error           1-cycle pulse on unknown command / aborted argument
//   frame_error         1-cycle pulse on low stop bit (or parity mismatch)
//   parity_error        (parity build only) 1-cycle pulse on parity mismatch
//   busy                receiver not idle or decoder collecting an argument
module busdebugger_command_rx #(
  parameter int BITWIDTH    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                serial_clock,
  input  logic                reset,
  input  logic [11:0]         clocks_per_bit,
  input  logic                rx_pin,
  output logic                dump_start,
  output logic                record_start,
  output logic                record_trigger,
  output logic [BITWIDTH-1:0] trigger_addr,
  output logic                trigger_addr_valid,
  output logic                cmd_error,
  output logic                frame_error,
`ifdef BUSDEBUGGER_CMD_RX_PARITY_EN
  output logic                parity_error,
`endif
  output logic                busy
);

  localparam int NDIG = BITWIDTH / 4;
  localparam int DW   = $clog2(NDIG + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_st_t;
  typedef enum logic {DEC_CMD, DEC_ARG} dec_st_t;

  // ---------------- synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  // ---------------- receiver ----------------
  rx_st_t      rx_st_q, rx_st_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_bad_q, par_bad_d;
  logic        strobe, fe_det, pe_det, tick;

  assign tick = (cnt_q == 12'd0);

  always_comb begin
    rx_st_d   = rx_st_q;
    cnt_d     = tick ? cnt_q : cnt_q - 12'd1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    strobe    = 1'b0;
    fe_det    = 1'b0;
    pe_det    = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (!rxs) begin
        // first sample lands mid start bit
        cnt_d   = (clocks_per_bit >> 1) - 12'd1;
        rx_st_d = RX_START;
      end
      RX_START: if (tick) begin
        if (!rxs) begin
          cnt_d     = clocks_per_bit - 12'd1;
          bit_d     = 3'd0;
          par_bad_d = 1'b0;
          rx_st_d   = RX_DATA;
        end else begin
          rx_st_d = RX_IDLE;  // glitch
        end
      end
      RX_DATA: if (tick) begin
        shreg_d = {rxs, shreg_q[7:1]};
        cnt_d   = clocks_per_bit - 12'd1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef BUSDEBUGGER_CMD_RX_PARITY_EN
          rx_st_d = RX_PAR;
`else
          rx_st_d = RX_STOP;
`endif
        end
      end
      RX_PAR: if (tick) begin
        par_bad_d = rxs ^ (^shreg_q);  // even parity
        cnt_d     = clocks_per_bit - 12'd1;
        rx_st_d   = RX_STOP;
      end
      RX_STOP: if (tick) begin
        if (rxs && !par_bad_q) strobe = 1'b1;
        if (!rxs || par_bad_q) fe_det = 1'b1;
        pe_det  = par_bad_q;
        rx_st_d = rxs ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: if (rxs) rx_st_d = RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      rx_st_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      rx_st_q   <= rx_st_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
    end
  end

  // ---------------- decoder ----------------
  dec_st_t             dec_q, dec_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [BITWIDTH-1:0] shadow_q, shadow_d, shadow_nx, addr_q, addr_d;
  logic                dump_q, dump_d, rec_q, rec_d, trig_q, trig_d;
  logic                vld_q, vld_d, cerr_q, cerr_d, fe_q, pe_q;
  logic                is_hex;
  logic [3:0]          nib;

  always_comb begin
    is_hex = 1'b0;
    nib    = shreg_q[3:0];
    if (shreg_q >= 8'h30 && shreg_q <= 8'h39) is_hex = 1'b1;
    else if ((shreg_q >= 8'h41 && shreg_q <= 8'h46) ||
             (shreg_q >= 8'h61 && shreg_q <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = shreg_q[3:0] + 4'd9;
    end
  end

  assign shadow_nx = BITWIDTH'({shadow_q, nib});

  always_comb begin
    dec_d    = dec_q;
    dig_d    = dig_q;
    shadow_d = shadow_q;
    addr_d   = addr_q;
    dump_d   = 1'b0;
    rec_d    = 1'b0;
    trig_d   = 1'b0;
    vld_d    = 1'b0;
    cerr_d   = 1'b0;
    if (dec_q == DEC_ARG && fe_q) begin
      // broken frame mid-argument aborts it, one cycle after frame_error
      cerr_d = 1'b1;
      dec_d  = DEC_CMD;
    end else if (strobe) begin
      if (dec_q == DEC_CMD) begin
        case (shreg_q)
          8'h44, 8'h64: dump_d = 1'b1;
          8'h52, 8'h72: rec_d  = 1'b1;
          8'h54, 8'h74: trig_d = 1'b1;
          8'h41, 8'h61: begin
            dig_d    = '0;
            shadow_d = '0;
            dec_d    = DEC_ARG;
          end
          8'h0D, 8'h0A, 8'h20: ;
          default: cerr_d = 1'b1;
        endcase
      end else if (is_hex) begin
        shadow_d = shadow_nx;
        dig_d    = dig_q + DW'(1);
        if (dig_q == DW'(NDIG - 1)) begin
          addr_d = shadow_nx;  // whole value lands in one cycle
          vld_d  = 1'b1;
          dec_d  = DEC_CMD;
        end
      end else begin
        cerr_d = 1'b1;
        dec_d  = DEC_CMD;
      end
    end
  end

  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      dec_q    <= DEC_CMD;
      dig_q    <= '0;
      shadow_q <= '0;
      addr_q   <= '0;
      dump_q   <= 1'b0;
      rec_q    <= 1'b0;
      trig_q   <= 1'b0;
      vld_q    <= 1'b0;
      cerr_q   <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      dec_q    <= dec_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      addr_q   <= addr_d;
      dump_q   <= dump_d;
      rec_q    <= rec_d;
      trig_q   <= trig_d;
      vld_q    <= vld_d;
      cerr_q   <= cerr_d;
      fe_q     <= fe_det;
      pe_q     <= pe_det;
    end
  end

  assign dump_start         = dump_q;
  assign record_start       = rec_q;
  assign record_trigger     = trig_q;
  assign trigger_addr       = addr_q;
  assign trigger_addr_valid = vld_q;
  assign cmd_error          = cerr_q;
  assign frame_error        = fe_q;
`ifdef BUSDEBUGGER_CMD_RX_PARITY_EN
  assign parity_error       = pe_q;
`endif
  assign busy = (rx_st_q != RX_IDLE) || (dec_q == DEC_ARG);

endmodule
